// File: rtl/fft_pitch_detect.sv
// fft_pitch_detect: frame FFT (single time-multiplexed radix-2 DIT butterfly) with peak-bin pitch estimate.
module fft_pitch_detect #(
  parameter int NSAMPLES = 1024,
  parameter int W = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        audio_input_valid,
  output logic                        audio_input_ready,
  input  logic signed [W-1:0]         audio_input_data,
  output logic                        pitch_output_valid,
  input  logic                        pitch_output_ready,
  output logic [$clog2(NSAMPLES)-1:0] pitch_output_data
);
  localparam int L = $clog2(NSAMPLES);
  localparam int H = NSAMPLES / 2;
  localparam int SW = $clog2(L);
  localparam int PW = 2 * W + 1;
  typedef enum logic [1:0] {COLLECT, FFT, MAG, OUT} state_t;

  function automatic logic signed [W-1:0] tw(input int k, input logic im);
    real a, v;
    int r;
    a = 6.283185307179586 * real'(k) / real'(NSAMPLES);
    v = (im ? -$sin(a) : $cos(a)) * real'(2 ** (W - 1));
    r = $rtoi($floor(v + 0.5));
    return (r > 2 ** (W - 1) - 1) ? W'(2 ** (W - 1) - 1) : W'(r);
  endfunction

  state_t               r_state;
  logic [L-1:0]         r_cnt;
  logic [SW-1:0]        r_s;
  logic [L-2:0]         r_j, r_k, r_idx;
  logic                 r_ph, r_ready, r_valid;
  logic [L-1:0]         r_data;
  logic [PW-1:0]        r_best;
  logic [2*W-1:0]       r_mem [NSAMPLES];
  logic signed [W+1:0]  r_tr, r_ti;

  logic signed [W-1:0]  w_twr [H];
  logic signed [W-1:0]  w_twi [H];
  logic [L-1:0]         w_rev, w_j, w_msk, w_pos, w_a, w_b;
  logic [L-2:0]         w_tk;
  logic signed [W-1:0]  w_ar, w_ai, w_br, w_bi, w_mr, w_mi;
  logic signed [PW-1:0] w_pr, w_pi;
  logic signed [W+2:0]  w_sr, w_si, w_dr, w_di;
  logic [PW-1:0]        w_mag;
  logic                 w_xfer, w_unused;

  for (genvar k = 0; k < H; k++) begin : g_tw
    assign w_twr[k] = tw(k, 1'b0);
    assign w_twi[k] = tw(k, 1'b1);
  end

  assign w_unused = pitch_output_ready;
  assign w_xfer = audio_input_valid && r_ready;
  assign w_rev = {<<{r_cnt}};
  // butterfly j of stage s: pairs (a, a+2^s), twiddle index pos*N/2^(s+1)
  assign w_j = {1'b0, r_j};
  assign w_msk = (L'(1) << r_s) - L'(1);
  assign w_pos = w_j & w_msk;
  assign w_a = ((w_j & ~w_msk) << 1) | w_pos;
  assign w_b = w_a | (L'(1) << r_s);
  assign w_tk = (L-1)'(w_pos << (L - 1 - r_s));
  assign {w_ar, w_ai} = r_mem[w_a];
  assign {w_br, w_bi} = r_mem[w_b];
  assign {w_mr, w_mi} = r_mem[{1'b0, r_k}];
  assign w_pr = PW'(w_br) * PW'(w_twr[w_tk]) - PW'(w_bi) * PW'(w_twi[w_tk]);
  assign w_pi = PW'(w_br) * PW'(w_twi[w_tk]) + PW'(w_bi) * PW'(w_twr[w_tk]);
  assign w_sr = (W+3)'(w_ar) + (W+3)'(r_tr);
  assign w_dr = (W+3)'(w_ar) - (W+3)'(r_tr);
  assign w_si = (W+3)'(w_ai) + (W+3)'(r_ti);
  assign w_di = (W+3)'(w_ai) - (W+3)'(r_ti);
  assign w_mag = $unsigned(PW'(w_mr) * PW'(w_mr) + PW'(w_mi) * PW'(w_mi));

  assign audio_input_ready = r_ready;
  assign pitch_output_valid = r_valid;
  assign pitch_output_data = r_data;

  always_ff @(posedge clk) begin
    r_tr <= (W+2)'(w_pr >>> (W - 1));
    r_ti <= (W+2)'(w_pi >>> (W - 1));
    if (r_state == COLLECT && w_xfer)
      r_mem[w_rev] <= {audio_input_data, W'(0)};
    else if (r_state == FFT && r_ph) begin
      r_mem[w_a] <= {W'(w_sr >>> 1), W'(w_si >>> 1)};
      r_mem[w_b] <= {W'(w_dr >>> 1), W'(w_di >>> 1)};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= COLLECT;
      r_cnt <= '0;
      r_s <= '0;
      r_j <= '0;
      r_k <= '0;
      r_idx <= '0;
      r_ph <= 1'b0;
      r_ready <= 1'b0;
      r_valid <= 1'b0;
      r_data <= '0;
      r_best <= '0;
    end else begin
      case (r_state)
        COLLECT: begin
          r_ready <= !(w_xfer && &r_cnt);
          if (w_xfer) begin
            r_cnt <= r_cnt + 1'b1;
            if (&r_cnt) begin
              r_state <= FFT;
              r_s <= '0;
              r_j <= '0;
              r_ph <= 1'b0;
            end
          end
        end
        FFT: begin
          r_ph <= !r_ph;
          if (r_ph) begin
            r_j <= r_j + 1'b1;
            if (&r_j) begin
              r_s <= r_s + 1'b1;
              if (r_s == SW'(L - 1)) begin
                r_state <= MAG;
                r_k <= (L-1)'(1);
                r_best <= '0;
                r_idx <= '0;
              end
            end
          end
        end
        MAG: begin
          r_k <= r_k + 1'b1;
          if (w_mag > r_best) begin
            r_best <= w_mag;
            r_idx <= r_k;
          end
          if (&r_k) begin
            r_state <= OUT;
            r_valid <= 1'b1;
            r_data <= (w_mag > r_best) ? L'(r_k) : L'(r_idx);
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_state <= COLLECT;
          r_cnt <= '0;
          r_ready <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fft_pitch_detect.sv
// tb_fft_pitch_detect: directed frames on a 64-point instance; bins are the analytic tone frequencies.
module tb_fft_pitch_detect;
  localparam int N = 64;
  localparam int W = 16;
  localparam int L = 6;
  localparam int LAT_MAX = 4 * (N / 2) * L + 2 * N;

  logic clk = 1'b0, reset = 1'b1, in_v = 1'b0, out_r = 1'b1;
  logic signed [W-1:0] in_d = '0;
  logic in_rdy, out_v;
  logic [L-1:0] out_d;
  int cyc = 0, n_pulse = 0, n_vec = 0, n_err = 0, t_last = 0, lat = 0, lat0 = 0, d = 0, p0 = 0;
  bit rdy_seen;

  fft_pitch_detect #(.NSAMPLES(N), .W(W)) dut (
    .clk(clk), .reset(reset),
    .audio_input_valid(in_v), .audio_input_ready(in_rdy), .audio_input_data(in_d),
    .pitch_output_valid(out_v), .pitch_output_ready(out_r), .pitch_output_data(out_d)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (out_v) n_pulse <= n_pulse + 1;

  function automatic int smp(int b1, int a1, int b2, int a2, int dc, bit sq, int n);
    real p;
    p = 6.283185307179586 * n / N;
    if (sq) return (n % 8 < 4) ? 32767 : -32767;
    return $rtoi($floor(a1 * $sin(p * b1) + a2 * $sin(p * b2) + 0.5)) + dc;
  endfunction

  task automatic chk(string tag, int got, int exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic send(int b1, int a1, int b2, int a2, int dc, bit sq, bit gap);
    for (int n = 0; n < N; n++) begin
      if (gap) while ($urandom_range(1, 0) == 1) @(negedge clk);
      for (int t = 0; t < 2000 && !in_rdy; t++) @(negedge clk);
      if (!in_rdy) begin
        $display("FAIL send_ready: observed 0 expected 1");
        $fatal(1, "input never became ready");
      end
      in_v = 1'b1;
      in_d = W'(smp(b1, a1, b2, a2, dc, sq, n));
      @(negedge clk);
      in_v = 1'b0;
    end
    t_last = cyc;
  endtask

  task automatic wait_pulse(string tag, int exp);
    rdy_seen = 0;
    for (int t = 0; t < 2000 && !out_v; t++) begin
      rdy_seen |= in_rdy;
      @(negedge clk);
    end
    rdy_seen |= in_rdy;
    lat = cyc - t_last;
    chk({tag, "_seen"}, int'(out_v), 1);
    chk({tag, "_data"}, int'(out_d), exp);
    chk({tag, "_rdy_low"}, int'(rdy_seen), 0);
    chk({tag, "_lat_bound"}, int'(lat <= LAT_MAX), 1);
    @(negedge clk);
    chk({tag, "_width"}, int'(out_v), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_valid", int'(out_v), 0);
    chk("rst_data", int'(out_d), 0);
    chk("rst_ready", int'(in_rdy), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", int'(in_rdy), 1);

    send(4, 16000, 0, 0, 0, 0, 0);
    chk("ready_after_last", int'(in_rdy), 0);
    wait_pulse("tone4", 4);
    lat0 = lat;

    send(31, 16000, 0, 0, 0, 0, 0);
    wait_pulse("nyq31", 31);
    send(1, 16000, 0, 0, 0, 0, 0);
    wait_pulse("low1", 1);
    p0 = n_pulse;
    for (int f = 0; f < 3; f++) begin
      send(4, 16000, 0, 0, 0, 0, 0);
      wait_pulse("b2b4", 4);
    end
    chk("b2b_pulses", n_pulse - p0, 3);

    send(6, 12000, 19, 6000, 0, 0, 0);
    wait_pulse("two_tone", 6);
    send(0, 0, 0, 0, 1000, 0, 0);
    wait_pulse("dc", 0);
    send(0, 0, 0, 0, 0, 0, 0);
    wait_pulse("zero", 0);

    out_r = 1'b0;
    send(4, 16000, 0, 0, 0, 0, 1);
    wait_pulse("gaps", 4);
    chk("gaps_latency", lat, lat0);
    send(5, 16000, 0, 0, 0, 0, 0);
    wait_pulse("noready5", 5);
    out_r = 1'b1;

    send(4, 16000, 0, 0, 0, 0, 0);
    repeat (100) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_valid", int'(out_v), 0);
    chk("abort_data", int'(out_d), 0);
    chk("abort_ready", int'(in_rdy), 0);
    reset = 1'b0;
    p0 = n_pulse;
    send(12, 16000, 0, 0, 0, 0, 0);
    wait_pulse("after_abort", 12);
    chk("abort_pulses", n_pulse - p0, 1);

    send(0, 0, 0, 0, 0, 1, 0);
    wait_pulse("square", 8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
